ahb_decoder_mux: RTL and testbench

//  Parametrised AHB-Lite address decoder plus slave-to-master response mux for N slaves.

---
 rtl/ahb_decoder_mux.sv | 130 +++++++++++++
 tb/tb_ahb_decoder_mux.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and slave response mux for SLAVE_NUM slaves, with a
// built-in default slave that answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR.
module ahb_decoder_mux #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned SLAVE_NUM = 4,
    parameter logic [SLAVE_NUM*AW-1:0] SLAVE_BASE = '0,
    parameter logic [SLAVE_NUM*AW-1:0] SLAVE_SIZE = '0,
    parameter int unsigned CW = 8
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic [AW-1:0]           haddr,
    input  logic [1:0]              htrans,
    output logic [SLAVE_NUM-1:0]    hsel,
    input  logic [SLAVE_NUM-1:0]    hreadyout_s,
    input  logic [SLAVE_NUM-1:0]    hresp_s,
    input  logic [SLAVE_NUM*DW-1:0] hrdata_s,
    output logic                    hready,
    output logic                    hresp,
    output logic [DW-1:0]           hrdata,
    output logic [CW-1:0]           err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [SLAVE_NUM-1:0]   dsel;
    logic                   xfer;
    logic                   err_inc;

    assign xfer = (htrans == 2'b10) || (htrans == 2'b11);

    // Region compare in AW+1 bits so a region ending at 2^AW never wraps.
    always_comb begin
        logic           found;
        logic [AW:0]    addr_x;
        logic [AW:0]    base_x;
        logic [AW:0]    size_x;
        hsel   = '0;
        found  = 1'b0;
        addr_x = {1'b0, haddr};
        base_x = '0;
        size_x = '0;
        for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
            base_x = {1'b0, SLAVE_BASE[i*AW +: AW]};
            size_x = {1'b0, SLAVE_SIZE[i*AW +: AW]};
            if (!found && (size_x != '0) && (addr_x >= base_x) &&
                (addr_x < base_x + size_x)) begin
                hsel[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    // Data-phase select follows the address phase whenever the bus advances.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dsel <= '0;
        end else if (hready) begin
            dsel <= hsel;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state   <= IDLE;
            err_cnt <= '0;
        end else begin
            state <= state_nx;
            if (err_inc && (err_cnt != {CW{1'b1}})) begin
                err_cnt <= err_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        err_inc  = 1'b0;
        case (state)
            IDLE, ERR2: begin
                if (hready && xfer && (hsel == '0)) begin
                    state_nx = ERR1;
                    err_inc  = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            ERR1:    state_nx = ERR2;
            default: state_nx = IDLE;
        endcase
    end

    // A selected slave owns the response; otherwise the default slave drives it.
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        if (dsel != '0) begin
            hready = |(dsel & hreadyout_s);
            hresp  = |(dsel & hresp_s);
            for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
                if (dsel[i]) begin
                    hrdata = hrdata | hrdata_s[i*DW +: DW];
                end
            end
        end else begin
            case (state)
                ERR1: begin
                    hready = 1'b0;
                    hresp  = 1'b1;
                end
                ERR2: begin
                    hready = 1'b1;
                    hresp  = 1'b1;
                end
                default: begin
                    hready = 1'b1;
                    hresp  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Bench for ahb_decoder_mux: two configurations share one stimulus stream and are
// checked every cycle against a transaction-level model plus literal expectations.
module tb_ahb_decoder_mux;

    logic         hclk = 1'b0;
    logic         hreset = 1'b1;
    logic [31:0]  haddr = 32'h0;
    logic [1:0]   htrans = 2'b00;
    logic [3:0]   hreadyout_s = 4'hF;
    logic [3:0]   hresp_s = 4'h0;
    logic [127:0] hrdata_s = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};

    logic [3:0]   sel_a, sel_b;
    logic         rdy_a, rdy_b, resp_a, resp_b;
    logic [31:0]  rdata_a, rdata_b;
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    always #5 hclk = ~hclk;

    ahb_decoder_mux #(
        .AW(32), .DW(32), .SLAVE_NUM(4),
        .SLAVE_BASE({32'h3000, 32'h2000, 32'h1000, 32'h0}),
        .SLAVE_SIZE({32'h1000, 32'h1000, 32'h1000, 32'h1000}),
        .CW(8)
    ) dut_a (
        .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans), .hsel(sel_a),
        .hreadyout_s(hreadyout_s), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
        .hready(rdy_a), .hresp(resp_a), .hrdata(rdata_a), .err_cnt(cnt_a)
    );

    ahb_decoder_mux #(
        .AW(32), .DW(32), .SLAVE_NUM(4),
        .SLAVE_BASE({32'hFFFF_F000, 32'h4000, 32'h1000, 32'h0}),
        .SLAVE_SIZE({32'h1000, 32'h0, 32'h1000, 32'h2000}),
        .CW(2)
    ) dut_b (
        .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans), .hsel(sel_b),
        .hreadyout_s(hreadyout_s), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
        .hready(rdy_b), .hresp(resp_b), .hrdata(rdata_b), .err_cnt(cnt_b)
    );

    // Model: address map per instance, data-phase owner, error cycles left, error count.
    longint unsigned cfg_base [2][4] = '{'{64'h0, 64'h1000, 64'h2000, 64'h3000},
                                         '{64'h0, 64'h1000, 64'h4000, 64'hFFFF_F000}};
    longint unsigned cfg_size [2][4] = '{'{64'h1000, 64'h1000, 64'h1000, 64'h1000},
                                         '{64'h2000, 64'h1000, 64'h0, 64'h1000}};
    int cnt_max [2] = '{255, 3};
    int m_dsl [2] = '{-1, -1};
    int m_err [2] = '{0, 0};
    int m_cnt [2] = '{0, 0};

    function automatic int decode(int k, logic [31:0] a);
        longint unsigned a64 = {32'h0, a};
        for (int i = 0; i < 4; i++) begin
            if (cfg_size[k][i] != 0 && a64 >= cfg_base[k][i] &&
                a64 < cfg_base[k][i] + cfg_size[k][i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_sel(int k);
        int d = decode(k, haddr);
        if (d < 0) return 4'b0000;
        return 4'b0001 << d;
    endfunction

    function automatic logic m_rdy(int k);
        if (m_dsl[k] >= 0) return hreadyout_s[m_dsl[k]];
        return (m_err[k] != 2);
    endfunction

    function automatic logic m_resp(int k);
        if (m_dsl[k] >= 0) return hresp_s[m_dsl[k]];
        return (m_err[k] != 0);
    endfunction

    function automatic logic [31:0] m_rdata(int k);
        if (m_dsl[k] >= 0) return hrdata_s[m_dsl[k]*32 +: 32];
        return 32'h0;
    endfunction

    always @(posedge hclk or posedge hreset) begin
        logic r;
        int   d;
        if (hreset) begin
            for (int k = 0; k < 2; k++) begin
                m_dsl[k] = -1;
                m_err[k] = 0;
                m_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                r = m_rdy(k);
                d = decode(k, haddr);
                if (!r) begin
                    if (m_err[k] == 2) m_err[k] = 1;
                end else begin
                    m_dsl[k] = d;
                    if (htrans[1] && d < 0) begin
                        m_err[k] = 2;
                        if (m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
                    end else begin
                        m_err[k] = 0;
                    end
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge hclk) begin
        if (started) begin
            chk("hsel_a", 32'(sel_a), 32'(m_sel(0)));
            chk("hready_a", 32'(rdy_a), 32'(m_rdy(0)));
            chk("hresp_a", 32'(resp_a), 32'(m_resp(0)));
            chk("hrdata_a", rdata_a, m_rdata(0));
            chk("errcnt_a", 32'(cnt_a), 32'(m_cnt[0]));
            chk("hsel_b", 32'(sel_b), 32'(m_sel(1)));
            chk("hready_b", 32'(rdy_b), 32'(m_rdy(1)));
            chk("hresp_b", 32'(resp_b), 32'(m_resp(1)));
            chk("hrdata_b", rdata_b, m_rdata(1));
            chk("errcnt_b", 32'(cnt_b), 32'(m_cnt[1]));
        end
    end

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    logic [31:0] dec_addr [7] = '{32'h1800, 32'h4000, 32'h3FFC, 32'hFFFF_FFFC,
                                  32'hFFFF_F000, 32'h1FFC, 32'h2000};
    logic [3:0]  dec_a [7] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0100};
    logic [3:0]  dec_b [7] = '{4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0001, 4'b0000};

    initial begin
        step();
        step();
        started = 1'b1;
        chk("rst_hready", 32'(rdy_a), 32'd1);
        chk("rst_hresp", 32'(resp_a), 32'd0);
        chk("rst_errcnt", 32'(cnt_a), 32'd0);
        chk("rst_hrdata", rdata_a, 32'd0);
        hreset = 1'b0;

        // Mapped NONSEQ to slave 1 with three wait states.
        haddr = 32'h1004;
        htrans = 2'b10;
        #1 chk("t1_hsel", 32'(sel_a), 32'b0010);
        step();
        haddr = 32'h0;
        htrans = 2'b00;
        hreadyout_s = 4'b1101;
        #1 chk("t1_rdata", rdata_a, 32'hB1B1_0001);
        chk("t1_wait1", 32'(rdy_a), 32'd0);
        chk("t1_b_rdy", 32'(rdy_b), 32'd1);
        step();
        step();
        chk("t1_wait3", 32'(rdy_a), 32'd0);
        step();
        hreadyout_s = 4'hF;
        #1 chk("t1_done", 32'(rdy_a), 32'd1);
        chk("t1_rdata2", rdata_a, 32'hB1B1_0001);
        step();

        // Unmapped NONSEQ: two-cycle ERROR.
        haddr = 32'h8000;
        htrans = 2'b10;
        step();
        haddr = 32'h0;
        htrans = 2'b00;
        #1 chk("t2_err1_rdy", 32'(rdy_a), 32'd0);
        chk("t2_err1_resp", 32'(resp_a), 32'd1);
        chk("t2_cnt_a", 32'(cnt_a), 32'd1);
        chk("t2_cnt_b", 32'(cnt_b), 32'd1);
        step();
        chk("t2_err2_rdy", 32'(rdy_a), 32'd1);
        chk("t2_err2_resp", 32'(resp_a), 32'd1);
        chk("t2_err2_rdata", rdata_a, 32'd0);
        step();

        // Back-to-back unmapped transfers, then IDLE/BUSY to unmapped.
        haddr = 32'h8000;
        htrans = 2'b10;
        step();
        step();
        chk("t3_err2_resp", 32'(resp_a), 32'd1);
        step();
        chk("t3_rerr_rdy", 32'(rdy_a), 32'd0);
        chk("t3_cnt_a", 32'(cnt_a), 32'd3);
        chk("t3_cnt_b", 32'(cnt_b), 32'd3);
        htrans = 2'b11;
        step();
        step();
        htrans = 2'b00;
        step();
        step();
        htrans = 2'b01;
        step();
        chk("t3_busy_rdy", 32'(rdy_a), 32'd1);
        chk("t3_busy_resp", 32'(resp_a), 32'd0);
        chk("t3_busy_cnt", 32'(cnt_a), 32'd4);
        htrans = 2'b00;
        step();
        chk("t3_idle_cnt", 32'(cnt_a), 32'd4);
        htrans = 2'b10;
        step();
        htrans = 2'b00;
        step();
        step();
        chk("t6_cnt_a", 32'(cnt_a), 32'd5);
        chk("t6_cnt_b_sat", 32'(cnt_b), 32'd3);

        // Decode: overlap priority, disabled region, top-of-map region, boundaries.
        for (int i = 0; i < 7; i++) begin
            haddr = dec_addr[i];
            #1;
            chk("t4_hsel_a", 32'(sel_a), 32'(dec_a[i]));
            chk("t4_hsel_b", 32'(sel_b), 32'(dec_b[i]));
        end
        step();

        // Reset while in ERR1 aborts immediately.
        haddr = 32'h8000;
        htrans = 2'b10;
        step();
        hreset = 1'b1;
        hreadyout_s = 4'h0;
        #1 chk("t5_rdy_a", 32'(rdy_a), 32'd1);
        chk("t5_resp_a", 32'(resp_a), 32'd0);
        chk("t5_cnt_a", 32'(cnt_a), 32'd0);
        chk("t5_cnt_b", 32'(cnt_b), 32'd0);
        chk("t5_rdy_b", 32'(rdy_b), 32'd1);
        haddr = 32'h1004;
        #1 chk("t5_hsel_rst", 32'(sel_a), 32'b0010);
        htrans = 2'b00;
        step();
        hreset = 1'b0;
        hreadyout_s = 4'hF;
        step();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
